// File: rtl/lt_compare_scheduler.sv
// lt_compare_scheduler: one digit-serial unsigned a<b engine shared round-robin by NREQ clients.
// Operands are scanned MSB-first, DIGIT bits per cycle, stopping at the first unequal digit.
module lt_compare_scheduler #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4,
   parameter int NREQ  = 4,
   parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_lt,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  busy
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int K_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_r;
   logic [ID_W-1:0]  last_grant_r;
   logic [K_W-1:0]   k_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;

   logic [ID_W-1:0]  grant_s;
   logic             found_s;
   logic [NREQ-1:0]  grant_oh_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;
   logic [DIGIT-1:0] a_dig_s;
   logic [DIGIT-1:0] b_dig_s;

   function automatic logic [NREQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
      logic [NREQ-1:0] oh;
      oh = {NREQ{1'b0}};
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Round-robin search starting just after the last served requester.
   always_comb begin
      int sum;
      sum     = 0;
      found_s = 1'b0;
      grant_s = {ID_W{1'b0}};
      for (int off = 1; off <= NREQ; off++) begin
         sum = (int'(last_grant_r) + off) % NREQ;
         if (!found_s && req_valid[ID_W'(sum)]) begin
            found_s = 1'b1;
            grant_s = ID_W'(sum);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grant decode, ready generation and operand selection for the winning requester.
   always_comb begin
      grant_oh_s = found_s ? to_onehot(grant_s) : {NREQ{1'b0}};
      if (state_r == IDLE) begin
         req_ready = grant_oh_s;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
      sel_a_s = {WIDTH{1'b0}};
      sel_b_s = {WIDTH{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         sel_a_s = sel_a_s | ({WIDTH{grant_oh_s[i]}} & req_a[i*WIDTH +: WIDTH]);
         sel_b_s = sel_b_s | ({WIDTH{grant_oh_s[i]}} & req_b[i*WIDTH +: WIDTH]);
      end
   end

   // The operand registers shift left each step, so the current digit is always on top.
   assign a_dig_s = a_r[WIDTH-1 -: DIGIT];
   assign b_dig_s = b_r[WIDTH-1 -: DIGIT];

   // Control FSM: accept, digit scan with early exit, response hold until handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         rsp_valid    <= 1'b0;
         rsp_lt       <= 1'b0;
         rsp_id       <= {ID_W{1'b0}};
         last_grant_r <= ID_W'(NREQ - 1);
         k_r          <= {K_W{1'b0}};
         busy         <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  a_r          <= sel_a_s;
                  b_r          <= sel_b_s;
                  rsp_id       <= grant_s;
                  last_grant_r <= grant_s;
                  k_r          <= {K_W{1'b0}};
                  busy         <= 1'b1;
                  state_r      <= SCAN;
               end
            end
            SCAN: begin
               if (a_dig_s != b_dig_s) begin
                  rsp_lt    <= (a_dig_s < b_dig_s);
                  rsp_valid <= 1'b1;
                  state_r   <= RESP;
               end else if (k_r == K_LAST) begin
                  rsp_lt    <= 1'b0;
                  rsp_valid <= 1'b1;
                  state_r   <= RESP;
               end else begin
                  k_r <= k_r + K_W'(1);
                  a_r <= a_r << DIGIT;
                  b_r <= b_r << DIGIT;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   lt_compare_scheduler_checker #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_checker (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_lt    (rsp_lt),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );
endmodule

// Protocol properties of the scheduler interface; no logic is driven from here.
module lt_compare_scheduler_checker #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input logic            clk,
   input logic            rst_n,
   input logic [NREQ-1:0] req_valid,
   input logic [NREQ-1:0] req_ready,
   input logic            rsp_valid,
   input logic            rsp_ready,
   input logic            rsp_lt,
   input logic [ID_W-1:0] rsp_id,
   input logic            busy
);
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));
   a_ready_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (req_ready & ~req_valid) == {NREQ{1'b0}});
   a_no_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
      busy |-> (req_ready == {NREQ{1'b0}}));
   a_rsp_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_valid |-> busy);
   a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_lt) && $stable(rsp_id)));
endmodule

// File: tb/tb_lt_compare_scheduler.sv
`timescale 1ns/1ps
// Bench for lt_compare_scheduler: directed scenarios then random traffic, every response
// checked against a scoreboard entry pushed when the request was accepted.
module tb_lt_compare_scheduler;
   localparam int WIDTH = 32;
   localparam int DIGIT = 4;
   localparam int NREQ  = 4;
   localparam int ID_W  = 2;
   localparam int NDIG  = WIDTH / DIGIT;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_lt;
   logic [ID_W-1:0]       rsp_id;
   logic                  busy;

   lt_compare_scheduler #(.WIDTH(WIDTH), .DIGIT(DIGIT), .NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_lt(rsp_lt), .rsp_id(rsp_id), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic [ID_W-1:0] id;
      logic            lt;
      int              lat;
      int              acc_cyc;
   } exp_t;

   exp_t             sb[$];
   int               acc_ids[$];
   int               vectors = 0;
   int               miscompares = 0;
   int               cyc_n = 0;
   int               n_acc = 0;
   int               n_rsp = 0;
   int               last_acc_cyc = -100;
   int               last_acc_id = -1;
   int               hs_cyc = -100;
   int               last_lat = -1;
   logic             last_lt = 1'b0;
   logic [ID_W-1:0]  last_id = '0;
   logic             prev_valid = 1'b0;
   logic             prev_stall = 1'b0;
   logic             prev_lt = 1'b0;
   logic [ID_W-1:0]  prev_id = '0;
   logic [WIDTH-1:0] oa [NREQ];
   logic [WIDTH-1:0] ob [NREQ];
   logic [NREQ-1:0]  va = '0;
   int               rem [NREQ];
   bit               rand_mode = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: position of the first differing digit sets the response latency.
   function automatic int lat_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      for (int k = 0; k < NDIG; k++) begin
         if (a[WIDTH-1-k*DIGIT -: DIGIT] != b[WIDTH-1-k*DIGIT -: DIGIT]) return 2 + k;
      end
      return 1 + NDIG;
   endfunction

   task automatic gen_pair(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] one;
      int k;
      int kind;
      one  = 32'd1;
      a    = $urandom;
      kind = $urandom_range(0, 3);
      k    = $urandom_range(0, NDIG - 1);
      if (kind == 0) begin
         b = $urandom;
      end else if (kind == 1) begin
         b = a;
      end else begin
         b = a;
         b[WIDTH-1-k*DIGIT -: DIGIT] = a[WIDTH-1-k*DIGIT -: DIGIT] ^ DIGIT'($urandom_range(1, 15));
         lo = (one << (WIDTH - DIGIT - k*DIGIT)) - one;
         b  = (b & ~lo) | ($urandom & lo);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = oa[i];
         req_b[i*WIDTH +: WIDTH] = ob[i];
      end
      req_valid = va;
   endtask

   function automatic bit drained();
      int s = 0;
      for (int i = 0; i < NREQ; i++) s += rem[i];
      return (va == '0) && (sb.size() == 0) && !busy && (s == 0);
   endfunction

   // One clock: monitor/score at the falling edge, then update requesters after the rising edge.
   task automatic cyc();
      int   acc;
      exp_t e;
      acc = -1;
      @(negedge clk);
      cyc_n++;
      if (rst_n) begin
         chk("ready_onehot0", ($countones(req_ready) <= 1), 1);
         if (busy) chk("ready_while_busy", req_ready, 0);
         if (prev_stall) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_lt", rsp_lt, prev_lt);
            chk("stall_id", rsp_id, prev_id);
         end
         if (rsp_valid && !prev_valid) begin
            chk("rsp_has_entry", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               last_lat = cyc_n - sb[0].acc_cyc;
               chk("latency", last_lat, sb[0].lat);
            end
         end
         if (rsp_valid && rsp_ready) begin
            chk("hs_has_entry", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("rsp_lt", rsp_lt, e.lt);
               chk("rsp_id", rsp_id, e.id);
            end
            n_rsp++;
            hs_cyc  = cyc_n;
            last_lt = rsp_lt;
            last_id = rsp_id;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.id = ID_W'(i);
               e.lt = (oa[i] < ob[i]);
               e.lat = lat_model(oa[i], ob[i]);
               e.acc_cyc = cyc_n;
               sb.push_back(e);
               acc_ids.push_back(i);
               acc = i;
               n_acc++;
               last_acc_cyc = cyc_n;
               last_acc_id = i;
            end
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_valid = rsp_valid;
         prev_lt    = rsp_lt;
         prev_id    = rsp_id;
      end else begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (acc >= 0) va[acc] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!va[i] && rem[i] > 0 && (!rand_mode || $urandom_range(0, 3) == 0)) begin
            gen_pair(oa[i], ob[i]);
            va[i] = 1'b1;
            rem[i]--;
         end
      end
      if (rand_mode) rsp_ready = ($urandom_range(0, 2) != 0);
      drive();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (!drained() && n < budget) begin
         cyc();
         n++;
      end
      chk("drain_in_budget", drained(), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int n0;
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] one;
      one = 32'd1;
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         oa[i] = '0; ob[i] = '0; rem[i] = 0;
      end
      drive();
      repeat (2) cyc();
      rst_n = 1'b1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_lt", rsp_lt, 0);
      chk("reset_rsp_id", rsp_id, 0);
      chk("reset_busy", busy, 0);
      chk("reset_req_ready", req_ready, 0);

      // All four valid together after reset: served 0,1,2,3.
      for (int i = 0; i < NREQ; i++) gen_pair(oa[i], ob[i]);
      va = 4'b1111; drive(); acc_ids.delete();
      wait_drain(200);
      chk("rr_all_count", acc_ids.size(), 4);
      for (int i = 0; i < 4; i++) if (i < acc_ids.size()) chk("rr_all_order", acc_ids[i], i);

      // Only requesters 0 and 2, each presenting twice: 0,2,0,2.
      gen_pair(oa[0], ob[0]); gen_pair(oa[2], ob[2]);
      rem[0] = 1; rem[2] = 1;
      va = 4'b0101; drive(); acc_ids.delete();
      wait_drain(200);
      chk("rr_02_count", acc_ids.size(), 4);
      for (int i = 0; i < 4; i++) if (i < acc_ids.size()) chk("rr_02_order", acc_ids[i], (i % 2) * 2);

      // MSB digit differs: earliest exit.
      oa[0] = 32'h8000_0000; ob[0] = 32'h7FFF_FFFF; va = 4'b0001; drive();
      wait_drain(50);
      chk("t1_lat", last_lat, 2); chk("t1_lt", last_lt, 0); chk("t1_id", last_id, 0);

      // LSB digit differs: full scan.
      oa[1] = 32'h0000_0001; ob[1] = 32'h0000_0002; va = 4'b0010; drive();
      wait_drain(50);
      chk("t2_lat", last_lat, 9); chk("t2_lt", last_lt, 1); chk("t2_id", last_id, 1);

      // Sweep the first mismatching digit over every position.
      for (int k = 0; k < NDIG; k++) begin
         oa[1] = 32'h5555_5555;
         ob[1] = oa[1];
         ob[1][WIDTH-1-k*DIGIT -: DIGIT] = (k % 2 == 0) ? 4'h6 : 4'h4;
         lo = (one << (WIDTH - DIGIT - k*DIGIT)) - one;
         ob[1] = (ob[1] & ~lo) | ($urandom & lo);
         va = 4'b0010; drive();
         wait_drain(50);
         chk("t2_sweep_lat", last_lat, 2 + k);
         chk("t2_sweep_lt", last_lt, (k % 2 == 0));
      end

      // Equal operands at both extremes.
      oa[3] = 32'hFFFF_FFFF; ob[3] = 32'hFFFF_FFFF; va = 4'b1000; drive();
      wait_drain(50);
      chk("t3_ones_lat", last_lat, 9); chk("t3_ones_lt", last_lt, 0); chk("t3_ones_id", last_id, 3);
      oa[3] = 32'h0; ob[3] = 32'h0; va = 4'b1000; drive();
      wait_drain(50);
      chk("t3_zero_lat", last_lat, 9); chk("t3_zero_lt", last_lt, 0); chk("t3_zero_id", last_id, 3);

      // Consumer stalls five cycles in RESP; next accept one cycle after the handshake.
      rsp_ready = 1'b0;
      gen_pair(oa[2], ob[2]); gen_pair(oa[3], ob[3]);
      va = 4'b1100; drive();
      n = 0;
      while (!rsp_valid && n < 20) begin cyc(); n++; end
      chk("t5_rsp_seen", rsp_valid, 1);
      chk("t5_first_id", last_acc_id, 2);
      repeat (5) begin
         cyc();
         chk("t5_hold_valid", rsp_valid, 1);
         chk("t5_hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      cyc();
      cyc();
      chk("t5_accept_gap", last_acc_cyc - hs_cyc, 1);
      chk("t5_second_id", last_acc_id, 3);
      wait_drain(50);

      // Reset while scanning digit 3 aborts the transaction.
      oa[0] = 32'h1234_5678; ob[0] = 32'h1234_5678; va = 4'b0001; drive();
      n = 0; n0 = n_acc;
      while (n_acc == n0 && n < 20) begin cyc(); n++; end
      chk("t6_accepted", n_acc - n0, 1);
      repeat (3) cyc();
      chk("t6_busy_before", busy, 1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      sb.delete();
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rsp_lt", rsp_lt, 0);
      repeat (3) cyc();
      chk("t6_no_rsp", rsp_valid, 0);
      for (int i = 0; i < NREQ; i++) gen_pair(oa[i], ob[i]);
      va = 4'b1111; drive(); acc_ids.delete();
      wait_drain(200);
      chk("t6_first_grant_cnt", (acc_ids.size() > 0), 1);
      if (acc_ids.size() > 0) chk("t6_first_grant", acc_ids[0], 0);

      // Random operands, random arrivals and random consumer back-pressure.
      n0 = n_rsp - n_acc;
      rand_mode = 1'b1;
      for (int i = 0; i < NREQ; i++) rem[i] = 400;
      wait_drain(40000);
      rand_mode = 1'b0;
      rsp_ready = 1'b1;
      chk("rand_one_rsp_per_accept", n_rsp - n_acc, n0);
      chk("rand_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
